// File: rtl/blur_pkg.sv
// Shared constants for the 3x3 Gaussian blur stage: kernel weights, tap offsets
// in issue order, normalisation shift and source BRAM read latency.
package blur_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } blur_state_t;

  localparam int NUM_TAPS     = 9;
  localparam int NORM_SHIFT   = 4;
  localparam int READ_LATENCY = 2;

  localparam logic [3:0] LAST_TAP = 4'd8;

  // Tap order: dy = -1..1 outer, dx = -1..1 inner
  localparam logic [2:0] KERNEL_W [NUM_TAPS] = '{
    3'd1, 3'd2, 3'd1,
    3'd2, 3'd4, 3'd2,
    3'd1, 3'd2, 3'd1
  };

  localparam logic signed [1:0] TAP_DX [NUM_TAPS] = '{
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1
  };

  localparam logic signed [1:0] TAP_DY [NUM_TAPS] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,  2'sd0,  2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };

endpackage

// File: rtl/image_blur_mac.sv
// Tap-indexed weighted accumulator for the blur stage: clears on tap 0, emits
// the normalised pixel on tap 8. Define BLUR_ROUND_EN for round-half-up output.
module blur_mac
  import blur_pkg::*;
#(
  parameter int BIT_DEPTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 tap_vld,
  input  logic [3:0]           tap_idx,
  input  logic [BIT_DEPTH-1:0] pix_in,
  output logic [BIT_DEPTH-1:0] pix_out,
  output logic                 pix_done
);

  localparam int ACC_W = BIT_DEPTH + 4;

  logic [ACC_W-1:0] acc_p0;
  logic [ACC_W-1:0] sum;

  // Kernel sum is 16, so the shifted result always fits BIT_DEPTH bits
  function automatic logic [BIT_DEPTH-1:0] normalise(input logic [ACC_W-1:0] s);
    logic [ACC_W:0] t;
`ifdef BLUR_ROUND_EN
    t = {1'b0, s} + (ACC_W+1)'(1 << (NORM_SHIFT - 1));
`else
    t = {1'b0, s};
`endif
    return t[NORM_SHIFT +: BIT_DEPTH];
  endfunction

  always_comb begin
    sum = ((tap_idx == 4'd0) ? '0 : acc_p0)
        + ACC_W'(pix_in) * ACC_W'(KERNEL_W[tap_idx]);
  end

  // Stage p0: accumulate; result registered on the final tap
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      acc_p0   <= '0;
      pix_out  <= '0;
      pix_done <= 1'b0;
    end else begin
      pix_done <= 1'b0;
      if (tap_vld) begin
        acc_p0 <= sum;
        if (tap_idx == LAST_TAP) begin
          pix_out  <= normalise(sum);
          pix_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/image_blur_full.sv
// BRAM-to-BRAM 3x3 Gaussian blur with edge clamping, one output per 9 cycles.
// Optional BLUR_ROUND_EN selects round-half-up normalisation inside blur_mac.
module image_blur_full
  import blur_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]      ext_read_addr,
  output logic                                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]                 ext_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]      ext_write_addr,
  output logic                                 ext_write_valid,
  output logic [BIT_DEPTH-1:0]                 ext_pixel_out,
  input  logic                                 start_in,
  output logic                                 blur_done,
  output logic                                 busy_out
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  blur_state_t state, state_nxt;
  logic        issue_en;
  logic        rd_active;
  logic [XW-1:0] cx, tx;
  logic [YW-1:0] cy, ty;
  logic [3:0]    tap, tap_iss;
  logic [AW-1:0] rd_addr;
  logic          vld_p0, vld_p1;
  logic [3:0]    tap_p0, tap_p1;
  logic          last_tap_p1;
  logic [AW-1:0] wr_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in)  state_nxt = RUN;
      RUN:     if (blur_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first tap is issued on the start edge itself so reads begin in cycle 1
  always_comb begin
    issue_en = ((state == IDLE) && start_in) || ((state == RUN) && rd_active);
    busy_out = (state == RUN);
  end

  always_comb begin
    tx = cx;
    ty = cy;
    if (TAP_DX[tap] < 0) begin
      if (cx != '0) tx = cx - XW'(1);
    end else if (TAP_DX[tap] > 0) begin
      if (cx != XW'(WIDTH - 1)) tx = cx + XW'(1);
    end
    if (TAP_DY[tap] < 0) begin
      if (cy != '0) ty = cy - YW'(1);
    end else if (TAP_DY[tap] > 0) begin
      if (cy != YW'(HEIGHT - 1)) ty = cy + YW'(1);
    end
    rd_addr = AW'(ty) * AW'(WIDTH) + AW'(tx);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cx                  <= '0;
      cy                  <= '0;
      tap                 <= '0;
      tap_iss             <= '0;
      rd_active           <= 1'b0;
      ext_read_addr       <= '0;
      ext_read_addr_valid <= 1'b0;
    end else begin
      ext_read_addr_valid <= issue_en;
      if (issue_en) begin
        ext_read_addr <= rd_addr;
        tap_iss       <= tap;
        rd_active     <= 1'b1;
        if (tap == LAST_TAP) begin
          tap <= '0;
          if (cx == XW'(WIDTH - 1)) begin
            cx <= '0;
            if (cy == YW'(HEIGHT - 1)) begin
              cy        <= '0;
              rd_active <= 1'b0;
            end else begin
              cy <= cy + YW'(1);
            end
          end else begin
            cx <= cx + XW'(1);
          end
        end else begin
          tap <= tap + 4'd1;
        end
      end
    end
  end

  // Stage p0/p1: tag pipe matching the two-cycle BRAM read latency
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= ext_read_addr_valid;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk_in) begin
    tap_p0 <= tap_iss;
    tap_p1 <= tap_p0;
  end

  assign last_tap_p1 = vld_p1 && (tap_p1 == LAST_TAP);

  // Stage p2: write address and frame-end strobe line up with the MAC result
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_cnt         <= '0;
      ext_write_addr <= '0;
      blur_done      <= 1'b0;
    end else begin
      blur_done <= 1'b0;
      if (last_tap_p1) begin
        ext_write_addr <= wr_cnt;
        if (wr_cnt == AW'(NPIX - 1)) begin
          blur_done <= 1'b1;
          wr_cnt    <= '0;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
    end
  end

  blur_mac #(
    .BIT_DEPTH (BIT_DEPTH)
  ) u_mac (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .tap_vld  (vld_p1),
    .tap_idx  (tap_p1),
    .pix_in   (ext_pixel_in),
    .pix_out  (ext_pixel_out),
    .pix_done (ext_write_valid)
  );

endmodule

// File: tb/tb_image_blur_full.sv
// Self-checking bench for image_blur_full on a 4x4 image with a 2-cycle BRAM
// model and a plain-arithmetic blur reference (honours BLUR_ROUND_EN).
module tb_image_blur_full;

  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [AW-1:0] ext_read_addr, ext_write_addr;
  logic          ext_read_addr_valid, ext_write_valid, blur_done, busy_out;
  logic [BD-1:0] ext_pixel_in, ext_pixel_out, rd_q1;

  logic [BD-1:0] mem [N];
  int exp_img [N];
  int cyc = 0;
  int start_cyc = 0;
  int errors = 0;
  int checks = 0;
  int wa_q[$], wd_q[$], wc_q[$], ra_q[$], rc_q[$], dc_q[$], bf_q[$], br_q[$];
  logic busy_prev = 1'b0;

  image_blur_full #(.BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .ext_read_addr       (ext_read_addr),
    .ext_read_addr_valid (ext_read_addr_valid),
    .ext_pixel_in        (ext_pixel_in),
    .ext_write_addr      (ext_write_addr),
    .ext_write_valid     (ext_write_valid),
    .ext_pixel_out       (ext_pixel_out),
    .start_in            (start_in),
    .blur_done           (blur_done),
    .busy_out            (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc          <= cyc + 1;
    rd_q1        <= mem[ext_read_addr];
    ext_pixel_in <= rd_q1;
  end

  always @(negedge clk_in) begin
    if (ext_write_valid) begin
      wa_q.push_back(int'(ext_write_addr));
      wd_q.push_back(int'(ext_pixel_out));
      wc_q.push_back(cyc - start_cyc);
    end
    if (ext_read_addr_valid) begin
      ra_q.push_back(int'(ext_read_addr));
      rc_q.push_back(cyc - start_cyc);
    end
    if (blur_done) dc_q.push_back(cyc - start_cyc);
    if (busy_prev && !busy_out) bf_q.push_back(cyc - start_cyc);
    if (!busy_prev && busy_out) br_q.push_back(cyc - start_cyc);
    busy_prev <= busy_out;
  end

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void compute_ref();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int s;
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            s += ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1)
               * int'(mem[clampi(y + dy, H - 1) * W + clampi(x + dx, W - 1)]);
`ifdef BLUR_ROUND_EN
        exp_img[y * W + x] = (s + 8) >> 4;
`else
        exp_img[y * W + x] = s >> 4;
`endif
      end
    end
  endfunction

  function automatic int got(input int idx);
    if (idx < wd_q.size()) return wd_q[idx];
    return -1;
  endfunction

  function automatic void fill(input int v);
    for (int i = 0; i < N; i++) mem[i] = BD'(v);
  endfunction

  task automatic start_frame();
    @(posedge clk_in); #1;
    start_in  = 1'b1;
    start_cyc = cyc;
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete();
    rc_q.delete(); dc_q.delete(); bf_q.delete(); br_q.delete();
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int restart_at);
    for (int i = 0; i < 400 && dc_q.size() == 0; i++) begin
      @(posedge clk_in); #1;
      start_in = (restart_at > 0) && (cyc - start_cyc == restart_at);
    end
    start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (dc_q.size() == 0) begin
      errors++;
      $display("FAIL frame_timeout: blur_done count %0d, required 1", dc_q.size());
    end
  endtask

  task automatic run_frame(input int restart_at);
    compute_ref();
    start_frame();
    wait_done(restart_at);
  endtask

  task automatic test_reset();
    rst_in = 1'b0; start_in = 1'b0;
    fill(0);
    repeat (3) @(posedge clk_in);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if ({ext_read_addr, ext_read_addr_valid, ext_write_addr, ext_write_valid,
           ext_pixel_out, blur_done, busy_out} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h, required 0", {ext_read_addr, ext_read_addr_valid,
                 ext_write_addr, ext_write_valid, ext_pixel_out, blur_done, busy_out});
      end
    end
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic test_constant();
    int bad;
    fill(100);
    run_frame(0);
    checks++;
    if (wa_q.size() != N) begin
      errors++; $display("FAIL const_write_count: got %0d, required %0d", wa_q.size(), N);
    end
    for (int p = 0; p < N && p < wa_q.size(); p++) begin
      checks++;
      if (wa_q[p] != p || wd_q[p] != 100 || wc_q[p] != 12 + 9 * p) begin
        errors++;
        $display("FAIL const_pixel%0d: got addr %0d val %0d cyc %0d, required addr %0d val 100 cyc %0d",
                 p, wa_q[p], wd_q[p], wc_q[p], p, 12 + 9 * p);
      end
    end
    checks++;
    if (dc_q.size() == 0 || dc_q[0] != 147) begin
      errors++; $display("FAIL const_done_cycle: got %0d, required 147", (dc_q.size() > 0) ? dc_q[0] : -1);
    end
    checks++;
    if (br_q.size() != 1 || br_q[0] != 1 || bf_q.size() != 1 || bf_q[0] != 148) begin
      errors++;
      $display("FAIL const_busy: rise %0d fall %0d, required rise 1 fall 148",
               (br_q.size() > 0) ? br_q[0] : -1, (bf_q.size() > 0) ? bf_q[0] : -1);
    end
    checks++;
    if (rc_q.size() != 9 * N || rc_q[0] != 1 || rc_q[rc_q.size() - 1] != 9 * N) begin
      errors++;
      $display("FAIL const_read_window: count %0d first %0d last %0d, required %0d 1 %0d",
               rc_q.size(), (rc_q.size() > 0) ? rc_q[0] : -1,
               (rc_q.size() > 0) ? rc_q[rc_q.size() - 1] : -1, 9 * N, 9 * N);
    end
    bad = -1;
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 9; k++) begin
        int ea;
        ea = clampi(p / W + k / 3 - 1, H - 1) * W + clampi(p % W + k % 3 - 1, W - 1);
        if (bad < 0 && (p * 9 + k >= ra_q.size() || ra_q[p * 9 + k] != ea)) bad = p * 9 + k;
      end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL const_tap_addr: first wrong tap index %0d, got %0d", bad,
               (bad < ra_q.size()) ? ra_q[bad] : -1);
    end
  endtask

  task automatic test_impulse();
    int want [6] = '{40, 20, 20, 10, 10, 0};
    int idx  [6] = '{5, 4, 1, 0, 10, 15};
    fill(0); mem[5] = 8'd160;
    run_frame(0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got(idx[i]) != want[i] || got(idx[i]) != exp_img[idx[i]]) begin
        errors++;
        $display("FAIL impulse_out%0d: got %0d, required %0d", idx[i], got(idx[i]), want[i]);
      end
    end
  endtask

  task automatic test_corner();
    fill(0); mem[0] = 8'd16;
    run_frame(0);
    checks++;
    if (got(0) != 9) begin
      errors++; $display("FAIL corner_out0: got %0d, required 9", got(0));
    end
    checks++;
    if (got(5) != 1) begin
      errors++; $display("FAIL corner_out5: got %0d, required 1", got(5));
    end
  endtask

  task automatic test_rounding();
    int want;
`ifdef BLUR_ROUND_EN
    want = 2;
`else
    want = 1;
`endif
    fill(0); mem[5] = 8'd24;
    run_frame(0);
    checks++;
    if (got(0) != want) begin
      errors++; $display("FAIL round_out0: got %0d, required %0d", got(0), want);
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (got(p) != exp_img[p]) begin
        errors++; $display("FAIL round_frame%0d: got %0d, required %0d", p, got(p), exp_img[p]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) mem[i] = BD'($urandom_range(0, 255));
      if (f == 2) mem[$urandom_range(0, N - 1)] = 8'hFF;
      run_frame(0);
      for (int p = 0; p < N; p++) begin
        checks++;
        if (got(p) != exp_img[p] || p >= wa_q.size() || wa_q[p] != p) begin
          errors++;
          $display("FAIL random%0d_pixel%0d: got %0d, required %0d", f, p, got(p), exp_img[p]);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    fill(100);
    run_frame(50);
    checks++;
    if (wc_q.size() != N || wc_q[N - 1] != 147 || wc_q[5] != 57) begin
      errors++;
      $display("FAIL restart_schedule: count %0d, required %0d writes ending at 147", wc_q.size(), N);
    end
    checks++;
    if (dc_q.size() != 1 || dc_q[0] != 147) begin
      errors++; $display("FAIL restart_done: got %0d, required 147", (dc_q.size() > 0) ? dc_q[0] : -1);
    end
  endtask

  task automatic test_reset_midframe();
    fill(100);
    start_frame();
    for (int i = 0; i < 100 && cyc - start_cyc < 40; i++) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if ({ext_read_addr, ext_read_addr_valid, ext_write_addr, ext_write_valid,
           ext_pixel_out, blur_done, busy_out} !== '0) begin
        errors++; $display("FAIL midreset_outputs: cycle %0d not all zero", i);
      end
    end
    rst_in = 1'b1;
    wa_q.delete();
    repeat (30) @(posedge clk_in);
    #1;
    checks++;
    if (wa_q.size() != 0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL midreset_stray: writes %0d busy %0b, required 0 0", wa_q.size(), busy_out);
    end
    run_frame(0);
    for (int p = 0; p < N; p++) begin
      checks++;
      if (got(p) != 100 || p >= wc_q.size() || wc_q[p] != 12 + 9 * p) begin
        errors++; $display("FAIL midreset_rerun%0d: got %0d, required 100", p, got(p));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) mem[i] = BD'($urandom_range(0, 255));
    compute_ref();
    start_frame();
    for (int i = 0; i < 400 && dc_q.size() == 0; i++) begin
      @(negedge clk_in); #1;
    end
    checks++;
    if (dc_q.size() == 0) begin
      errors++; $display("FAIL b2b_timeout_a: blur_done count 0, required 1");
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (got(p) != exp_img[p]) begin
        errors++; $display("FAIL b2b_a_pixel%0d: got %0d, required %0d", p, got(p), exp_img[p]);
      end
    end
    for (int i = 0; i < N; i++) mem[i] = BD'($urandom_range(0, 255));
    compute_ref();
    start_frame();
    wait_done(0);
    checks++;
    if (wc_q.size() == 0 || wc_q[0] != 12) begin
      errors++; $display("FAIL b2b_first_write: got %0d, required 12", (wc_q.size() > 0) ? wc_q[0] : -1);
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (got(p) != exp_img[p]) begin
        errors++; $display("FAIL b2b_b_pixel%0d: got %0d, required %0d", p, got(p), exp_img[p]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_constant();
    test_impulse();
    test_corner();
    test_rounding();
    test_random();
    test_restart_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
